regfile_write_scheduler: RTL and testbench

//  Owns the single write port of the 32x32 register file. Clears every register after reset (or on

---
 rtl/regfile_write_scheduler_pkg.sv | 9 +
 rtl/regfile_write_scheduler_rr_arbiter.sv | 38 +++
 rtl/regfile_write_scheduler.sv | 120 ++++++++++++
 tb/tb_regfile_write_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_scheduler_pkg.sv
// regfile_pkg: shared sizes and FSM state type for the register-file
// write-port scheduler.
package regfile_pkg;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

  typedef enum logic {ST_INIT, ST_RUN} rfw_state_t;
endpackage

// File: rtl/regfile_write_scheduler_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin picker.
//   valid [N]  - request lines
//   ptr        - highest-priority index this cycle (register lives in parent)
//   grant [N]  - one-hot grant, all zero when nothing is valid
//   gidx       - index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gidx
);

  logic          found;
  logic [PW:0]   sum;   // one extra bit: ptr+k reaches at most 2N-2
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: owns the register file's single write port.
// After reset (or clear_req) it writes zero to registers 0..NUM_REGS-1,
// one per cycle, then arbitrates NUM_REQ writeback requesters round-robin.
//   clk, reset(active-low async)  - clock / reset
//   clear_req                     - pulse in RUN restarts the clear sequence
//   req_valid/req_addr/req_data   - per-requester write requests (flat slices)
//   req_ready                     - combinational one-hot grant
//   rf_regWrite/rf_writeRegister/rf_writeData - registered write port
//   init_done                     - high while in RUN (clear complete)
import regfile_pkg::*;

module regfile_write_scheduler #(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_req,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_regWrite,
  output logic [ADDR_W-1:0]         rf_writeRegister,
  output logic [DATA_W-1:0]         rf_writeData,
  output logic                      init_done
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  rfw_state_t          state_q, state_d;
  logic [ADDR_W:0]     clr_idx;   // extra bit: counts to NUM_REGS without wrapping
  logic [PW-1:0]       rr_ptr, rr_nxt;
  logic [NUM_REQ-1:0]  grant;
  logic [PW-1:0]       gidx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                clr_last;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .gidx  (gidx)
  );

  assign clr_last = (clr_idx == (ADDR_W+1)'(NUM_REGS-1));
  assign rr_nxt   = (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // Next state + grant gating. A clear request in RUN takes the port for
  // that cycle, so nobody is granted.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      ST_INIT: if (clr_last) state_d = ST_RUN;
      ST_RUN: begin
        if (clear_req) state_d   = ST_INIT;
        else           req_ready = grant;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Mux the granted requester's slice (req_ready is one-hot or zero)
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_idx          <= '0;
      rr_ptr           <= '0;
      rf_regWrite      <= 1'b0;
      rf_writeRegister <= '0;
      rf_writeData     <= '0;
      init_done        <= 1'b0;
    end else begin
      rf_regWrite <= 1'b0;
      case (state_q)
        ST_INIT: begin
          rf_regWrite      <= 1'b1;
          rf_writeRegister <= clr_idx[ADDR_W-1:0];
          rf_writeData     <= '0;
          clr_idx          <= clr_idx + 1'b1;
          if (clr_last) init_done <= 1'b1;
        end
        ST_RUN: begin
          if (clear_req) begin
            clr_idx   <= '0;
            init_done <= 1'b0;
          end else if (|req_ready) begin
            // r0 is hardwired zero: complete the handshake but never write it
            rf_regWrite      <= (sel_addr != '0);
            rf_writeRegister <= sel_addr;
            rf_writeData     <= sel_data;
            rr_ptr           <= rr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: expected register-file
// writes are queued with the cycle they must appear in and popped by a
// negedge monitor.
module tb_regfile_write_scheduler;
  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             clear_req;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             rf_regWrite;
  logic [AW-1:0]    rf_writeRegister;
  logic [DW-1:0]    rf_writeData;
  logic             init_done;

  regfile_write_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .clear_req        (clear_req),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .rf_regWrite      (rf_regWrite),
    .rf_writeRegister (rf_writeRegister),
    .rf_writeData     (rf_writeData),
    .init_done        (init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  exp_t sb[$];
  int   gnt_q[$];
  int   errs   = 0;
  int   checks = 0;

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_clear(int base);
    for (int i = 0; i < 32; i++) sb.push_back('{a: AW'(i), d: '0, c: base + i});
  endtask

  task automatic set_req(int i, logic [AW-1:0] a, logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic wait_neg(int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  // Present one write on requester i, wait (bounded) for ready, then drop valid.
  task automatic do_req(int i, logic [AW-1:0] a, logic [DW-1:0] d, output int gc);
    set_req(i, a, d);
    req_valid[i] = 1'b1;
    gc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        gc = cyc;
        break;
      end
    end
    if (gc < 0) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  // Monitor: scoreboard pops, grant sanity, acceptance -> expected write next cycle
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].c < cyc) begin
      chk("missed_wr", 0, 1);
      void'(sb.pop_front());
    end
    if (rf_regWrite) begin
      if (sb.size() == 0) chk("unexp_wr", {27'd0, rf_writeRegister}, 64'hffff);
      else begin
        e = sb.pop_front();
        chk("wr_addr", rf_writeRegister, e.a);
        chk("wr_data", rf_writeData, e.d);
        chk("wr_cyc", cyc, e.c);
      end
    end
    chk("ready_1hot", ($countones(req_ready) <= 1), 1);
    chk("ready_gate", req_ready & ~req_valid & {NR{1'b1}}, 0);
    chk("ready_init", req_ready & {NR{~init_done}}, 0);
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        gnt_q.push_back(i);
        if (req_addr[i*AW +: AW] != '0)
          sb.push_back('{a: req_addr[i*AW +: AW], d: req_data[i*DW +: DW], c: cyc + 1});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, gc, n;
    reset     = 1'b0;
    clear_req = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;

    // Reset state, with requests pending to prove ready stays low
    repeat (3) @(posedge clk); #1;
    req_valid = 3'b111;
    #1;
    chk("rst_we",    rf_regWrite, 0);
    chk("rst_addr",  rf_writeRegister, 0);
    chk("rst_data",  rf_writeData, 0);
    chk("rst_done",  init_done, 0);
    chk("rst_ready", req_ready, 0);
    req_valid = '0;

    // 1: clear sequence after release
    @(posedge clk); #1;
    reset = 1'b1;
    c0 = cyc;
    push_clear(c0 + 1);
    wait_neg(c0 + 31);
    chk("t1_done_early", init_done, 0);
    wait_neg(c0 + 32);
    chk("t1_done", init_done, 1);
    wait_neg(c0 + 33);
    chk("t1_idle_we", rf_regWrite, 0);

    // 2: single write, granted immediately, visible next cycle
    @(posedge clk); #1;
    n = cyc;
    do_req(0, 5'd5, 32'hDEADBEEF, gc);
    chk("t2_gnt_cyc", gc, n);
    repeat (2) @(posedge clk); #1;
    do_req(2, 5'd7, 32'h0000_0777, gc);   // leaves rr_ptr at 0

    // 3: all valid for 6 cycles -> 0,1,2,0,1,2
    @(posedge clk); #1;
    gnt_q.delete();
    set_req(0, 5'd10, 32'hA0A0_0000);
    set_req(1, 5'd11, 32'hB1B1_1111);
    set_req(2, 5'd12, 32'hC2C2_2222);
    req_valid = 3'b111;
    repeat (6) @(posedge clk); #1;
    req_valid = '0;
    chk("t3_count", gnt_q.size(), 6);
    for (int k = 0; k < 6 && k < gnt_q.size(); k++) chk("t3_order", gnt_q[k], k % 3);

    // 4: write to r0 completes handshake, advances rr_ptr, no rf write
    repeat (2) @(posedge clk); #1;
    do_req(1, 5'd0, 32'h1, gc);
    @(negedge clk);
    chk("t4_r0_we", rf_regWrite, 0);
    @(posedge clk); #1;
    set_req(0, 5'd3, 32'h3333_0003);
    set_req(2, 5'd4, 32'h4444_0004);
    req_valid = 3'b101;
    @(negedge clk);
    chk("t4_ptr_adv", req_ready, 3'b100);
    @(posedge clk); #1;
    req_valid = 3'b001;
    @(negedge clk);
    chk("t4_next", req_ready, 3'b001);
    @(posedge clk); #1;
    req_valid = '0;

    // 5: clear_req while req2 valid
    @(posedge clk); #1;
    set_req(2, 5'd20, 32'h2020_2020);
    req_valid = 3'b100;
    clear_req = 1'b1;
    n = cyc;
    push_clear(n + 2);
    @(negedge clk);
    chk("t5_nogrant", req_ready, 0);
    @(posedge clk); #1;
    clear_req = 1'b0;
    gc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready[2]) begin
        gc = cyc;
        break;
      end
    end
    chk("t5_gnt_cyc", gc, n + 33);
    chk("t5_done", init_done, 1);
    @(posedge clk); #1;
    req_valid = '0;

    // 6: async reset during clear write 10
    repeat (2) @(posedge clk); #1;
    clear_req = 1'b1;
    n = cyc;
    push_clear(n + 2);
    @(posedge clk); #1;
    clear_req = 1'b0;
    wait_neg(n + 12);
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    chk("t6_we",   rf_regWrite, 0);
    chk("t6_addr", rf_writeRegister, 0);
    chk("t6_data", rf_writeData, 0);
    chk("t6_done", init_done, 0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    c0 = cyc;
    push_clear(c0 + 1);
    wait_neg(c0 + 32);
    chk("t6_redone", init_done, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
